bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter WIDTH, default 14, binary input width in bits.
REQ-002 Parameter DIGITS, default 4, number of BCD output digits.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 start  input  1  request to convert; sampled only in IDLE.
REQ-006 bin  input  WIDTH  unsigned binary value; captured on the edge that accepts start.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse marking a new result on bcd/ovf.
REQ-009 bcd  output  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0].
REQ-010 ovf  output  1  high when the captured bin is 10^DIGITS or greater; registered with bcd.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and FINISH.
REQ-012 In IDLE with start=1, the block SHALL capture bin into a shift register, clear the BCD working register and the cycle counter, and enter SHIFT.
REQ-013 Each SHIFT cycle SHALL add 3 to every working digit whose value is 5 or more, and SHALL then shift {working digits, binary shift register} left by one bit.
REQ-014 After exactly WIDTH SHIFT cycles the FSM SHALL enter FINISH; the counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-015 In FINISH, bcd and ovf SHALL update and done SHALL be 1 for that cycle only; the FSM SHALL return to IDLE on the next edge.
REQ-016 Latency: done SHALL first be visible after the (WIDTH+1)th rising edge following the edge that sampled start (15 edges at defaults).
REQ-017 busy SHALL be 1 in SHIFT and FINISH, and 0 in IDLE.
REQ-018 start SHALL be ignored while busy=1, with no queuing and no effect on the conversion in flight.
REQ-019 start held high SHALL begin a new conversion on the first IDLE cycle after done, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-020 Overflow: if the captured bin >= 10^DIGITS, ovf SHALL be 1 and bcd SHALL saturate to all digits 9; otherwise ovf SHALL be 0.
REQ-021 bcd and ovf SHALL hold their last values between done pulses; bin changing after capture SHALL have no effect.
REQ-022 Every digit of bcd SHALL always lie in 0..9.

Reset
REQ-023 reset=1 SHALL force the FSM to IDLE and set busy=0, done=0, bcd=0, ovf=0, and clear the counter and working registers.
REQ-024 reset asserted mid-conversion SHALL abort it, and no done SHALL follow.
REQ-025 reset SHALL take priority over start on the same edge.

Structure
REQ-026 The state encoding, the DIGITS and WIDTH defaults and the saturation constant SHALL live in a shared package, display_pkg.
REQ-027 Per-digit correction SHALL be done by DIGITS instances of the existing add3 sub-module, with no inline duplicate of its table.
REQ-028 Overflow detection SHALL be a registered compare of the captured value against 10^DIGITS, made at capture time.

Verification
REQ-029 reset, then start with bin=0 -> done after 15 edges; bcd=16'h0000, ovf=0, busy high for exactly 15 cycles.
REQ-030 bin=1234 -> bcd=16'h1234, ovf=0; bin=9999 -> bcd=16'h9999, ovf=0.
REQ-031 bin=10000 and bin=16383 -> bcd=16'h9999, ovf=1.
REQ-032 bin=42 started, then start pulsed with bin=77 at cycle 5 -> a single done with bcd=16'h0042.
REQ-033 bin=500 started, reset asserted at cycle 8 -> busy=0, bcd=0 and no done; a fresh start with bin=7 then gives bcd=16'h0007.
REQ-034 start held high with bin stepping 0..9999 -> one done every 16 cycles, and every result matches the decimal value.

Source files
------------

// File: rtl/display_pkg.sv
// display_pkg -- shared definitions for the binary-to-BCD converter.
//   state_t    : converter FSM encoding (IDLE / SHIFT / FINISH)
//   WIDTH_DEF  : default binary input width
//   DIGITS_DEF : default number of BCD digits
//   SAT_DIGIT  : digit value used when the result saturates on overflow
//   pow10()    : 10^n, used to build the overflow threshold
package display_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   localparam int WIDTH_DEF  = 14;
   localparam int DIGITS_DEF = 4;

   localparam logic [3:0] SAT_DIGIT = 4'd9;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] p;
      p = 64'd1;
      for (int i = 0; i < n; i++) p = p * 64'd10;
      return p;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// add3 -- double-dabble digit correction.
//   i_d : working BCD digit before the shift
//   o_d : digit plus 3 when it is 5 or more, otherwise unchanged
module add3 (
   input  logic [3:0] i_d,
   output logic [3:0] o_d
);

   always_comb begin
      o_d = i_d;
      if (i_d >= 4'd5) o_d = i_d + 4'd3;
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq -- sequential (shift-and-add-3) binary to packed BCD converter.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   start : conversion request, only looked at in IDLE
//   bin   : unsigned binary value, captured when start is accepted
//   busy  : high in SHIFT and FINISH
//   done  : one-cycle pulse when bcd/ovf carry a new result
//   bcd   : packed BCD result, digit 0 (units) in bits [3:0]
//   ovf   : captured value was >= 10^DIGITS; bcd then reads all 9s
module bin2bcd_seq
   import display_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int          CW    = $clog2(WIDTH + 1);
   localparam logic [63:0] LIMIT = pow10(DIGITS);

   state_t                r_state, w_next;
   logic [WIDTH-1:0]      r_bin;
   logic [4*DIGITS-1:0]   r_work;
   logic [4*DIGITS-1:0]   w_adj;
   logic [CW-1:0]         r_cnt;
   logic                  r_ovf_cap;
   logic                  r_done;
   logic                  r_ovf;
   logic [4*DIGITS-1:0]   r_bcd;
   logic                  w_last;
   logic                  w_busy;

   // One correction unit per working digit; outputs feed the shift.
   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      add3 u_add3 (
         .i_d (r_work[4*g +: 4]),
         .o_d (w_adj[4*g +: 4])
      );
   end

   // Counter holds the number of shifts already done; this is the last one.
   assign w_last = (r_cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_busy = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy = 1'b0;
            if (start) w_next = ST_SHIFT;
         end
         ST_SHIFT:  if (w_last) w_next = ST_FINISH;
         ST_FINISH: w_next = ST_IDLE;
         default: begin
            w_next = ST_IDLE;
            w_busy = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin     <= '0;
         r_work    <= '0;
         r_cnt     <= '0;
         r_ovf_cap <= 1'b0;
         r_done    <= 1'b0;
         r_ovf     <= 1'b0;
         r_bcd     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_bin     <= bin;
                  r_work    <= '0;
                  r_cnt     <= '0;
                  // Decided now so later changes on bin cannot matter.
                  r_ovf_cap <= (64'(bin) >= LIMIT);
               end
            end
            ST_SHIFT: begin
               {r_work, r_bin} <= {w_adj, r_bin} << 1;
               r_cnt           <= r_cnt + CW'(1);
            end
            ST_FINISH: begin
               // Overflowed values lose high bits in r_work, so substitute all 9s.
               r_done <= 1'b1;
               r_ovf  <= r_ovf_cap;
               r_bcd  <= r_ovf_cap ? {DIGITS{SAT_DIGIT}} : r_work;
            end
            default: ;
         endcase
      end
   end

   assign busy = w_busy;
   assign done = r_done;
   assign bcd  = r_bcd;
   assign ovf  = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq -- self-checking bench for bin2bcd_seq at default parameters.
module tb_bin2bcd_seq;

   localparam int W = 14;
   localparam int D = 4;
   localparam int N_B2B = 200;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [W-1:0]   bin;
   logic           busy;
   logic           done;
   logic [4*D-1:0] bcd;
   logic           ovf;

   int n_cmp = 0;
   int n_err = 0;

   bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd),
      .ovf   (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: decimal digits by plain arithmetic, saturated at 9999.
   function automatic logic [15:0] model_bcd(input int v);
      logic [15:0] r;
      int p;
      if (v >= 10000) return 16'h9999;
      r = '0;
      p = 1;
      for (int i = 0; i < D; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic model_ovf(input int v);
      return v >= 10000;
   endfunction

   // Single conversion: latency, busy length, result, one-cycle done, hold.
   task automatic run_conv(input int v, input string tag);
      int edges, bc;
      logic got;
      bin   = W'(v);
      start = 1'b1;
      tick();
      start = 1'b0;
      bin   = W'($urandom);
      bc    = busy ? 1 : 0;
      edges = 0;
      got   = 1'b0;
      while (!got && edges < 40) begin
         tick();
         edges++;
         if (busy) bc++;
         if (done) got = 1'b1;
      end
      chk({tag, "_latency"}, edges, 15);
      chk({tag, "_busycyc"}, bc, 15);
      chk({tag, "_bcd"}, bcd, model_bcd(v));
      chk({tag, "_ovf"}, ovf, model_ovf(v));
      tick();
      chk({tag, "_donepulse"}, done, 1'b0);
      chk({tag, "_hold"}, bcd, model_bcd(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, de, q[$], nxt, ev, prev_e, ndone;
      logic [15:0] bsave;

      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_bcd",  bcd,  16'h0);
      chk("rst_ovf",  ovf,  1'b0);
      reset = 1'b0;
      tick();

      run_conv(0,     "zero");
      run_conv(1234,  "v1234");
      run_conv(9999,  "v9999");
      run_conv(10000, "v10000");
      run_conv(16383, "v16383");
      for (int k = 0; k < 4; k++) run_conv(int'($urandom_range(0, 16383)), "rnd");

      // start during a conversion is ignored
      bin   = W'(42);
      start = 1'b1;
      tick();
      nd = 0; de = 0; bsave = '0;
      for (int e = 1; e <= 40; e++) begin
         if (e == 5) begin start = 1'b1; bin = W'(77); end
         else start = 1'b0;
         tick();
         if (done) begin nd++; de = e; bsave = bcd; end
      end
      chk("busy_start_ndone", nd, 1);
      chk("busy_start_edge", de, 15);
      chk("busy_start_bcd", bsave, 16'h0042);

      // reset mid-conversion aborts it
      bin   = W'(500);
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_bcd",  bcd,  16'h0);
      chk("abort_ovf",  ovf,  1'b0);
      nd = 0;
      for (int e = 0; e < 30; e++) begin
         tick();
         if (done) nd++;
      end
      chk("abort_nodone", nd, 0);
      run_conv(7, "after_abort");

      // reset wins over start on the same edge
      reset = 1'b1;
      start = 1'b1;
      bin   = W'(321);
      tick();
      reset = 1'b0;
      start = 1'b0;
      chk("rst_prio_busy", busy, 1'b0);
      tick();
      chk("rst_prio_idle", busy, 1'b0);

      // start held high: one result every 16 cycles, bin scrambled while busy
      start  = 1'b1;
      nxt    = 0;
      bin    = W'(nxt);
      q.push_back(nxt);
      ev     = 0;
      prev_e = -1;
      ndone  = 0;
      while (ndone < N_B2B && ev < N_B2B * 16 + 64) begin
         tick();
         ev++;
         if (done) begin
            if (q.size() == 0) chk("b2b_spurious", 1, 0);
            else begin
               nxt = q.pop_front();
               chk("b2b_bcd", bcd, model_bcd(nxt));
               chk("b2b_ovf", ovf, model_ovf(nxt));
            end
            if (prev_e >= 0) chk("b2b_gap", ev - prev_e, 16);
            prev_e = ev;
            ndone++;
            if (ndone < N_B2B) begin
               if (ndone < 10)       nxt = ndone * 1111;
               else if (ndone % 3 == 0) nxt = (ndone * 50) % 10000;
               else                  nxt = int'($urandom_range(0, 9999));
               bin = W'(nxt);
               q.push_back(nxt);
            end else start = 1'b0;
         end else if (busy) bin = W'($urandom);
      end
      chk("b2b_count", ndone, N_B2B);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
